// File: rtl/spi_shift_reg.sv
// Word-level SPI master shifter: MSB-first transmit on mosi, receive sampled on rising
// serial-clock strobes. All state lives in the clk domain; the strobes are plain enables.
module spi_shift_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sclkPosEdge,
   input  logic             sclkNegEdge,
   input  logic             start,
   input  logic [WIDTH-1:0] txData,
   input  logic             miso,
   output logic             mosi,
   output logic             cs_n,
   output logic [WIDTH-1:0] rxData,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             done_q, done_d;
   logic             cnt_full, cnt_zero;

   assign cnt_full = (bit_cnt_q == LastCnt);
   assign cnt_zero = (bit_cnt_q == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               tx_shift_d = txData;
               rx_shift_d = '0;
               bit_cnt_d  = '0;
               state_d    = StShift;
            end
         end
         StShift: begin
            // A rising strobe wins over a coincident falling strobe.
            if (sclkPosEdge) begin
               if (!cnt_full) begin
                  rx_shift_d = {rx_shift_q[WIDTH-2:0], miso};
                  bit_cnt_d  = bit_cnt_q + 1'b1;
               end
            end else if (sclkNegEdge) begin
               if (cnt_full) begin
                  rx_data_d = rx_shift_q;
                  done_d    = 1'b1;
                  state_d   = StIdle;
               end else if (!cnt_zero) begin
                  // Leading falling edge (count zero) keeps the MSB on the line.
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mosi = 1'b0;
      cs_n = 1'b1;
      busy = 1'b0;
      if (state_q == StShift) begin
         mosi = tx_shift_q[WIDTH-1];
         cs_n = 1'b0;
         busy = 1'b1;
      end
   end

   assign rxData = rx_data_q;
   assign done   = done_q;

endmodule

// File: tb/tb_spi_shift_reg.sv
// Randomised scoreboard bench for spi_shift_reg: a strobe generator, an SPI slave model,
// and a monitor that pops expected words on every done pulse.
module tb_spi_shift_reg;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int          Budget = 2000;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             sclkPosEdge = 1'b0;
   logic             sclkNegEdge = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] txData = '0;
   logic             miso;
   logic             mosi, cs_n, busy, done;
   logic [WIDTH-1:0] rxData;

   typedef struct packed {
      logic [WIDTH-1:0] tx;
      logic [WIDTH-1:0] rx;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Strobe generator state (owned by the generator process).
   int  div = 2;
   bit  gen_en = 1'b0;
   bit  inject_neg = 1'b0;
   bit  sclk_lvl = 1'b0;
   int  gen_cnt = 0;

   // Slave model: shifts miso_word out MSB first, advancing after each sampled rising strobe.
   logic [WIDTH-1:0] miso_word = '0;
   bit  loop_mode = 1'b0;
   int  slave_k = 0;
   bit  slave_pend = 1'b0;
   bit  slave_clr = 1'b1;

   // Monitor state.
   logic [WIDTH-1:0] rx_model = '0;
   logic [WIDTH-1:0] mosi_bits = '0;
   int  nbits = 0;
   int  pos_cnt = 0;
   bit  prev_valid = 1'b0;
   bit  prev_busy = 1'b0;
   bit  prev_mosi = 1'b0;
   bit  prev_neg = 1'b0;
   bit  want_done_low = 1'b0;

   function automatic logic slave_bit(input logic [WIDTH-1:0] w, input int k);
      logic b;
      b = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (k == int'(WIDTH) - 1 - i) b = w[i];
      end
      return b;
   endfunction

   assign miso = loop_mode ? mosi : slave_bit(miso_word, slave_k);

   spi_shift_reg #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sclkPosEdge(sclkPosEdge),
      .sclkNegEdge(sclkNegEdge),
      .start      (start),
      .txData     (txData),
      .miso       (miso),
      .mosi       (mosi),
      .cs_n       (cs_n),
      .rxData     (rxData),
      .busy       (busy),
      .done       (done)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   // Strobe generator and slave advance, both just after each rising clk edge.
   initial forever begin
      @(posedge clk);
      #1;
      if (slave_clr) slave_k = 0;
      else if (slave_pend) slave_k++;
      if (gen_en) begin
         sclkPosEdge = 1'b0;
         sclkNegEdge = 1'b0;
         gen_cnt++;
         if (gen_cnt >= div) begin
            gen_cnt  = 0;
            sclk_lvl = !sclk_lvl;
            if (sclk_lvl) sclkPosEdge = 1'b1;
            else sclkNegEdge = 1'b1;
         end
      end else begin
         gen_cnt     = 0;
         sclk_lvl    = 1'b0;
         sclkPosEdge = 1'b0;
         sclkNegEdge = inject_neg;
      end
   end

   // Monitor: samples on the falling clk edge, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         prev_valid    = 1'b0;
         prev_busy     = 1'b0;
         want_done_low = 1'b0;
         rx_model      = '0;
         nbits         = 0;
         pos_cnt       = 0;
         slave_pend    = 1'b0;
         slave_clr     = 1'b1;
      end else begin
         if (want_done_low) check("done_single_cycle", done, 0);
         want_done_low = 1'b0;
         check("cs_n_low_while_busy", cs_n, !busy);
         if (prev_valid && mosi != prev_mosi)
            check("mosi_moves_on_negstrobe", prev_neg || (busy != prev_busy), 1);
         if (busy && !prev_busy) begin
            nbits     = 0;
            pos_cnt   = 0;
            mosi_bits = '0;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               exp_t e;
               e        = exp_q.pop_front();
               rx_model = e.rx;
               check("rxData_word", rxData, e.rx);
               check("mosi_bit_sequence", mosi_bits, e.tx);
               check("mosi_bit_count", nbits, WIDTH);
               check("posedge_strobes_before_done", pos_cnt, WIDTH);
               check("done_after_negstrobe", prev_neg, 1);
               check("cs_n_high_with_done", cs_n, 1);
               check("busy_low_with_done", busy, 0);
            end
            want_done_low = 1'b1;
         end else begin
            check("rxData_held", rxData, rx_model);
         end
         slave_clr  = !busy;
         slave_pend = busy && sclkPosEdge;
         if (busy && sclkPosEdge) begin
            pos_cnt++;
            if (nbits < int'(WIDTH)) begin
               mosi_bits = {mosi_bits[WIDTH-2:0], mosi};
               nbits++;
            end
         end
         prev_valid = 1'b1;
         prev_busy  = busy;
         prev_mosi  = mosi;
         prev_neg   = sclkNegEdge;
      end
   end

   task automatic start_xfer(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] mw,
                             input bit lp);
      exp_t e;
      @(posedge clk);
      #2;
      txData    = tx;
      miso_word = mw;
      loop_mode = lp;
      start     = 1'b1;
      e.tx      = tx;
      e.rx      = lp ? tx : mw;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check({"timeout_", name}, got, 1);
   endtask

   initial begin
      logic [WIDTH-1:0] tx_r, mw_r;
      int seen;
      bit got;

      // Reset, then idle with no start.
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_mosi", mosi, 0);
      check("idle_cs_n", cs_n, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rxData", rxData, 8'h00);

      // Loopback of 8'hA5 with a divide-by-2 serial clock.
      div    = 2;
      gen_en = 1'b1;
      start_xfer(8'hA5, 8'h00, 1'b1);
      wait_done("loopback_a5");

      // miso tied high, txData zero, leading falling strobe injected before any rising one.
      gen_en = 1'b0;
      repeat (2) @(posedge clk);
      start_xfer(8'h00, 8'hFF, 1'b0);
      inject_neg = 1'b1;
      @(posedge clk);
      #2 inject_neg = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("lead_neg_mosi_msb_00", mosi, 0);
      check("lead_neg_still_busy", busy, 1);
      gen_en = 1'b1;
      wait_done("miso_high");

      // Same leading-edge case with a set MSB, so a premature shift would be visible.
      gen_en = 1'b0;
      repeat (2) @(posedge clk);
      tx_r = 8'h96;
      start_xfer(tx_r, 8'h00, 1'b1);
      inject_neg = 1'b1;
      @(posedge clk);
      #2 inject_neg = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("lead_neg_mosi_msb_96", mosi, tx_r[WIDTH-1]);
      gen_en = 1'b1;
      wait_done("lead_neg_96");

      // A start pulsed mid-transfer is ignored; the new word goes out after done.
      mw_r = WIDTH'($urandom);
      start_xfer(8'hA5, mw_r, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      txData = 8'h3C;
      start  = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      wait_done("first_of_pair");
      start_xfer(8'h3C, WIDTH'($urandom), 1'b0);
      wait_done("second_of_pair");

      // Asynchronous reset after the 4th rising strobe.
      start_xfer(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
      got = 1'b0;
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         #1;
         if (pos_cnt >= 4) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("timeout_fourth_posedge", got, 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("midreset_mosi", mosi, 0);
      check("midreset_cs_n", cs_n, 1);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_rxData", rxData, 8'h00);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      start_xfer(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
      wait_done("after_reset");

      // start held high: three back-to-back transfers of the same word.
      tx_r = WIDTH'($urandom);
      mw_r = WIDTH'($urandom);
      begin
         exp_t e;
         e.tx = tx_r;
         e.rx = mw_r;
         repeat (3) exp_q.push_back(e);
      end
      @(posedge clk);
      #2;
      txData    = tx_r;
      miso_word = mw_r;
      loop_mode = 1'b0;
      start     = 1'b1;
      seen      = 0;
      for (int i = 0; i < 3 * Budget; i++) begin
         @(negedge clk);
         #1;
         if (done) seen++;
         if (seen == 3) break;
      end
      start = 1'b0;
      check("back_to_back_dones", seen, 3);
      repeat (5) @(negedge clk);
      check("no_transfer_after_release", busy, 0);

      // Randomised transfers over several divider settings.
      for (int n = 0; n < 8; n++) begin
         div = int'($urandom_range(4, 1));
         start_xfer(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1, 0)));
         wait_done("random");
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_shift_reg.md
Name: spi_shift_reg

Overview:
- Word-level SPI master shifter for the serial link.
- Loads a parallel transmit word and produces the serial MOSI bit that feeds the downstream negedge-retiming flop (mosiFF's d input).
- Samples MISO on serial-clock rising strobes and returns a parallel receive word.
- Driven by the single-cycle sclkPosEdge/sclkNegEdge strobes from serialClock. Everything runs in the clk domain; the strobes are never used as clocks.

Parameters:
- WIDTH, 8, bits per transfer (>=2)
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- reset_n  input  1  asynchronous active-low reset
- sclkPosEdge  input  1  one-clk strobe: serial clock rising edge
- sclkNegEdge  input  1  one-clk strobe: serial clock falling edge
- start  input  1  request a transfer; sampled only in IDLE
- txData  input  WIDTH  word to send, MSB first; captured on accepted start
- miso  input  1  serial data in
- mosi  output  1  serial data out (to mosiFF d)
- cs_n  output  1  chip select, low for the whole transfer
- rxData  output  WIDTH  last received word; held until the next done
- busy  output  1  high from load until done
- done  output  1  one-clk pulse on transfer completion

Behaviour:
- Reset (reset_n=0, asynchronous; takes effect immediately, mid-transfer included):
  - state=IDLE; mosi=0, cs_n=1, busy=0, done=0, rxData=0.
  - Internal txShift, rxShift and bitCnt cleared.
- States: IDLE, SHIFT.
- IDLE:
  - mosi=0, cs_n=1, busy=0.
  - On start=1 at clk edge t: txShift<=txData, rxShift<=0, bitCnt<=0, state<=SHIFT.
  - Strobes are ignored in the start cycle.
  - From t+1: cs_n=0, busy=1, mosi=txData[WIDTH-1].
- SHIFT, mosi = txShift[WIDTH-1] at all times:
  - sclkPosEdge with bitCnt<WIDTH: rxShift<={rxShift[WIDTH-2:0],miso}, bitCnt<=bitCnt+1.
  - sclkPosEdge with bitCnt==WIDTH: ignored.
  - sclkNegEdge with bitCnt==0: ignored. This is the leading edge before the first sample, so the MSB stays valid.
  - sclkNegEdge with 0<bitCnt<WIDTH: txShift<={txShift[WIDTH-2:0],1'b0}, presenting the next bit.
  - sclkNegEdge with bitCnt==WIDTH: rxData<=rxShift, done<=1 for exactly one clk, cs_n<=1, busy<=0, mosi<=0, state<=IDLE.
- Completion latency: done asserts the clk after the first negedge strobe that follows the WIDTH-th posedge strobe.
- Simultaneous strobes in one cycle (illegal from serialClock): the posedge action is taken and the negedge is dropped.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as done is not accepted, because the state is still SHIFT. IDLE lasts at least one clk between transfers.
- mosi changes only on clk edges coincident with a negedge strobe (or load/exit), so the downstream negedge retiming sees stable data.
- bitCnt never exceeds WIDTH; no wrap-around.

Test Plan:
- Reset then idle, no start for 50 clk -> mosi=0, cs_n=1, busy=0, done=0, rxData=8'h00.
- Loopback, WIDTH=8, start with txData=8'hA5, miso=mosi, strobes from serialClock divider 2 -> mosi bit sequence 1,0,1,0,0,1,0,1; rxData=8'hA5; done high exactly one clk; cs_n low throughout and high with done.
- miso tied 1, txData=8'h00 -> mosi stays 0 for all bits, rxData=8'hFF; a negedge strobe injected before the first posedge leaves mosi=0 (MSB) and bitCnt=0.
- Second start (txData=8'h3C) pulsed mid-transfer of 8'hA5 -> ignored, first word completes unchanged; a new start after done sends 8'h3C correctly.
- reset_n pulled low after the 4th posedge strobe -> outputs go immediately to reset values, rxData=8'h00, no done pulse; the next start gives a clean full transfer.
- Back-to-back: start held high continuously -> transfers are separated by at least one IDLE clk with cs_n=1, and each done is a single-cycle pulse.
